// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
//   state_e           : responder FSM states (idle, wait, done)
//   DepthWordsDefault : default number of 32-bit words in the array
//   LatencyDefault    : default stall cycles per access
//   CntW              : latency counter width (covers LATENCY up to 15)
package dmem_pkg;

   localparam int unsigned DepthWordsDefault = 256;
   localparam int unsigned LatencyDefault    = 2;
   localparam int unsigned CntW              = 4;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDone
   } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit word RAM: synchronous write, registered read.
// Contents are never cleared; only the read register is reset.
//   clk_i, reset_i : clock, synchronous active-high reset (read register only)
//   we_i           : write wdata_i to word idx_i on this edge
//   re_i           : load word idx_i (or zero when rd_zero_i) into rdata_o
//   idx_i          : word index
//   wdata_i        : write data
//   rdata_o        : registered read data, held between reads
module dmem_array #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned IdxW        = 8
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            we_i,
   input  logic            re_i,
   input  logic            rd_zero_i,
   input  logic [IdxW-1:0] idx_i,
   input  logic [31:0]     wdata_i,
   output logic [31:0]     rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= rd_zero_i ? 32'h0 : mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. Each load/store stalls
// the pipeline for exactly LATENCY cycles; the access happens on the edge that
// enters the done state, using operands latched when the request was accepted.
// Optional macro DMEM_ERR_EN adds a sticky err_o for misaligned, out-of-range
// or read+write requests (faulting write dropped, faulting read returns 0).
//   clk_i, reset_i     : clock, synchronous active-high reset
//   memreadM_i         : load request
//   memwriteM_i        : store request (wins over load)
//   addrM_i            : byte address
//   writedataM_i       : store data
//   readdata_o         : registered load data, held until the next read
//   stall_o            : freeze request for F/D/E/M
//   err_o              : sticky access error (DMEM_ERR_EN only)
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DepthWordsDefault,
   parameter int unsigned LATENCY     = LatencyDefault
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        memreadM_i,
   input  logic        memwriteM_i,
   input  logic [31:0] addrM_i,
   input  logic [31:0] writedataM_i,
   output logic [31:0] readdata_o,
`ifdef DMEM_ERR_EN
   output logic        err_o,
`endif
   output logic        stall_o
);

   localparam int unsigned     IdxW    = $clog2(DEPTH_WORDS);
   localparam logic [CntW-1:0] LastCnt = CntW'(LATENCY - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            wr_q, wr_d;
   logic            rd_q, rd_d;

   logic            req;
   logic            acc_go;
   logic [31:0]     acc_addr;
   logic [31:0]     acc_wdata;
   logic            acc_wr;
   logic            acc_rd;
   logic            fault;

   assign req = memreadM_i | memwriteM_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      stall_o = 1'b0;
      acc_go  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               stall_o = 1'b1;
               addr_d  = addrM_i;
               wdata_d = writedataM_i;
               wr_d    = memwriteM_i;
               rd_d    = memreadM_i;
               cnt_d   = CntW'(1);
               if (LATENCY == 1) begin
                  state_d = StDone;
                  acc_go  = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            stall_o = 1'b1;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               state_d = StDone;
               acc_go  = 1'b1;
            end
         end
         StDone: begin
            // Request may still be asserted here; it is not re-accepted.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (reset_i) begin
         stall_o = 1'b0;
      end
   end

   // With LATENCY==1 the access fires straight from idle, before the operand
   // registers load, so the live inputs are used in that case.
   always_comb begin
      if (state_q == StIdle) begin
         acc_addr  = addrM_i;
         acc_wdata = writedataM_i;
         acc_wr    = memwriteM_i;
         acc_rd    = memreadM_i;
      end else begin
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_wr    = wr_q;
         acc_rd    = rd_q;
      end
   end

`ifdef DMEM_ERR_EN
   logic err_q;

   assign fault = (acc_addr[1:0] != 2'b00)
               || ((acc_addr >> (IdxW + 2)) != 32'h0)
               || (acc_wr && acc_rd);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         err_q <= 1'b0;
      end else if (acc_go && fault) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   logic unused_acc;

   assign fault      = 1'b0;
   assign unused_acc = ^{acc_addr[31:IdxW+2], acc_addr[1:0], acc_rd};
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
   end

   // Reset at the done-entry edge cancels the access entirely.
   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IdxW        (IdxW)
   ) u_array (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .we_i      (acc_go && acc_wr && !fault && !reset_i),
      .re_i      (acc_go && !acc_wr && !reset_i),
      .rd_zero_i (fault),
      .idx_i     (acc_addr[IdxW+1:2]),
      .wdata_i   (acc_wdata),
      .rdata_o   (readdata_o)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset_i;
   int          checks = 0;
   int          failures = 0;

   // LATENCY=2 instance
   logic        rd_i, wr_i, stall;
   logic [31:0] addr_i, wdata_i, rdata;
   // LATENCY=1 instance
   logic        rd1, wr1, stall1;
   logic [31:0] addr1, wdata1, rdata1;
   // LATENCY=15 instance
   logic        rd15, wr15, stall15;
   logic [31:0] addr15, wdata15, rdata15;
`ifdef DMEM_ERR_EN
   logic        err, err1, err15;
`endif

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
      .clk_i(clk), .reset_i(reset_i), .memreadM_i(rd_i), .memwriteM_i(wr_i),
      .addrM_i(addr_i), .writedataM_i(wdata_i), .readdata_o(rdata),
`ifdef DMEM_ERR_EN
      .err_o(err),
`endif
      .stall_o(stall)
   );

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
      .clk_i(clk), .reset_i(reset_i), .memreadM_i(rd1), .memwriteM_i(wr1),
      .addrM_i(addr1), .writedataM_i(wdata1), .readdata_o(rdata1),
`ifdef DMEM_ERR_EN
      .err_o(err1),
`endif
      .stall_o(stall1)
   );

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) dut15 (
      .clk_i(clk), .reset_i(reset_i), .memreadM_i(rd15), .memwriteM_i(wr15),
      .addrM_i(addr15), .writedataM_i(wdata15), .readdata_o(rdata15),
`ifdef DMEM_ERR_EN
      .err_o(err15),
`endif
      .stall_o(stall15)
   );

   // Present a request on the LATENCY=2 instance at the current idle cycle and
   // run until the done cycle; inputs are scrambled once accepted.
   task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, output int nstall);
      rd_i = rd; wr_i = wr; addr_i = a; wdata_i = d;
      #1;
      nstall = 0;
      while (stall && nstall < 40) begin
         nstall++;
         @(posedge clk); #1;
         addr_i = 32'h0000_00FC; wdata_i = 32'hBAD0_BAD0;
         #1;
      end
   endtask

   task automatic go_idle();
      rd_i = 1'b0; wr_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      rd_i = 0; wr_i = 0; addr_i = 0; wdata_i = 0;
      rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
      rd15 = 0; wr15 = 0; addr15 = 0; wdata15 = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++; $display("FAIL reset_stall got=%b exp=0", stall);
      end
      checks++;
      if (rdata !== 32'h0) begin
         failures++; $display("FAIL reset_readdata got=%h exp=0", rdata);
      end
`ifdef DMEM_ERR_EN
      checks++;
      if (err !== 1'b0) begin
         failures++; $display("FAIL reset_err got=%b exp=0", err);
      end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      int n;
      run_access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, n);
      checks++;
      if (n !== 2) begin
         failures++; $display("FAIL write_stall_len got=%0d exp=2", n);
      end
      checks++;
      if (rdata !== 32'h0) begin
         failures++; $display("FAIL write_readdata_kept got=%h exp=0", rdata);
      end
      go_idle();
   endtask

   task automatic test_read();
      int n;
      run_access(1'b1, 1'b0, 32'h10, 32'h0, n);
      checks++;
      if (n !== 2) begin
         failures++; $display("FAIL read_stall_len got=%0d exp=2", n);
      end
      checks++;
      if (rdata !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL read_data got=%h exp=deadbeef", rdata);
      end
      go_idle();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL read_hold got=%h exp=deadbeef", rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_stall;
      for (int i = 0; i < 6; i++) begin
         if (i < 3) begin
            rd_i = 0; wr_i = 1; addr_i = 32'h20; wdata_i = 32'h5A5A_1234;
         end else begin
            rd_i = 1; wr_i = 0; addr_i = 32'h20; wdata_i = 32'h0;
         end
         #1;
         exp_stall = ((i % 3) != 2);
         checks++;
         if (stall !== exp_stall) begin
            failures++; $display("FAIL b2b_stall[%0d] got=%b exp=%b", i, stall, exp_stall);
         end
         if (i == 5) begin
            checks++;
            if (rdata !== 32'h5A5A_1234) begin
               failures++; $display("FAIL b2b_data got=%h exp=5a5a1234", rdata);
            end
         end
         @(posedge clk); #1;
      end
      rd_i = 0; wr_i = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_access();
      int n;
      run_access(1'b0, 1'b1, 32'h30, 32'h1111_2222, n);
      go_idle();
      rd_i = 0; wr_i = 1; addr_i = 32'h30; wdata_i = 32'h3333_4444;
      @(posedge clk); #1;   // now in WAIT, about to enter DONE
      reset_i = 1'b1; wr_i = 0;
      @(posedge clk); #1;
      reset_i = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++; $display("FAIL midreset_stall got=%b exp=0", stall);
      end
      @(posedge clk); #1;
      run_access(1'b1, 1'b0, 32'h30, 32'h0, n);
      checks++;
      if (rdata !== 32'h1111_2222) begin
         failures++; $display("FAIL midreset_word12 got=%h exp=11112222", rdata);
      end
      go_idle();
   endtask

   task automatic test_sweep();
      int n;
      // LATENCY=1
      rd1 = 0; wr1 = 1; addr1 = 32'h8; wdata1 = 32'h1234_5678;
      #1; n = 0;
      while (stall1 && n < 40) begin n++; @(posedge clk); #2; end
      checks++;
      if (n !== 1) begin
         failures++; $display("FAIL lat1_write_len got=%0d exp=1", n);
      end
      wr1 = 0; @(posedge clk); #1;
      rd1 = 1; addr1 = 32'h8;
      #1; n = 0;
      while (stall1 && n < 40) begin n++; @(posedge clk); #2; end
      checks++;
      if (n !== 1) begin
         failures++; $display("FAIL lat1_read_len got=%0d exp=1", n);
      end
      checks++;
      if (rdata1 !== 32'h1234_5678) begin
         failures++; $display("FAIL lat1_data got=%h exp=12345678", rdata1);
      end
      rd1 = 0; @(posedge clk); #1;
      // LATENCY=15
      rd15 = 0; wr15 = 1; addr15 = 32'h40; wdata15 = 32'hA5A5_A5A5;
      #1; n = 0;
      while (stall15 && n < 40) begin n++; @(posedge clk); #2; end
      checks++;
      if (n !== 15) begin
         failures++; $display("FAIL lat15_write_len got=%0d exp=15", n);
      end
      wr15 = 0; @(posedge clk); #1;
      rd15 = 1; addr15 = 32'h40;
      #1; n = 0;
      while (stall15 && n < 40) begin n++; @(posedge clk); #2; end
      checks++;
      if (rdata15 !== 32'hA5A5_A5A5) begin
         failures++; $display("FAIL lat15_data got=%h exp=a5a5a5a5", rdata15);
      end
      rd15 = 0; @(posedge clk); #1;
   endtask

   task automatic test_config();
      int n;
`ifdef DMEM_ERR_EN
      run_access(1'b0, 1'b1, 32'h13, 32'h0BAD_F00D, n);
      checks++;
      if (err !== 1'b1) begin
         failures++; $display("FAIL err_set got=%b exp=1", err);
      end
      go_idle();
      run_access(1'b1, 1'b0, 32'h10, 32'h0, n);
      checks++;
      if (rdata !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL err_mem_kept got=%h exp=deadbeef", rdata);
      end
      checks++;
      if (err !== 1'b1) begin
         failures++; $display("FAIL err_sticky got=%b exp=1", err);
      end
      go_idle();
`else
      run_access(1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, n);
      go_idle();
      run_access(1'b1, 1'b0, 32'h0, 32'h0, n);
      checks++;
      if (rdata !== 32'hCAFE_F00D) begin
         failures++; $display("FAIL wrap_word0 got=%h exp=cafef00d", rdata);
      end
      go_idle();
`endif
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_mid_access();
      test_sweep();
      test_config();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
